// File: rtl/s16_wb_sram_responder.sv
// rtl/s16_wb_sram_responder.sv - Wishbone-style single-port word SRAM responder for the S16X4A bus
//
// Parameters:
//   DEPTH_LOG2  : SRAM holds 2^DEPTH_LOG2 16-bit words (4..15), indexed by adr_i[DEPTH_LOG2:1]
//   WAIT_STATES : extra cycles between request acceptance and ack_o (0..15)
// Ports:
//   clk_i, reset          : clock, synchronous active-high reset
//   adr_i[15:1]           : word address
//   we_i, cyc_i, stb_i    : write enable, bus cycle, strobe (request = cyc_i & stb_i)
//   sel_i[1:0]            : byte lanes ([0] = bits 7:0, [1] = bits 15:8)
//   vda_i, vpa_i          : valid data / program address cycle-type qualifiers
//   dat_i                 : write data
//   ack_o, dat_o          : one-cycle acknowledge and read data (zero outside ack)
//   err_o                 : error acknowledge, present only when S16_RESP_ERR_EN is defined
//   fetch_cnt_o           : acked opcode fetches (vpa_i & ~vda_i)
//   data_cnt_o            : acked data cycles (vda_i, literal fetches included)
// Configuration macro: S16_RESP_ERR_EN

module s16_wb_sram_responder #(
  parameter int DEPTH_LOG2  = 10,
  parameter int WAIT_STATES = 0
) (
  input  logic        clk_i,
  input  logic        reset,
  input  logic [15:1] adr_i,
  input  logic        we_i,
  input  logic        cyc_i,
  input  logic        stb_i,
  input  logic [1:0]  sel_i,
  input  logic        vda_i,
  input  logic        vpa_i,
  input  logic [15:0] dat_i,
  output logic        ack_o,
  output logic [15:0] dat_o,
`ifdef S16_RESP_ERR_EN
  output logic        err_o,
`endif
  output logic [15:0] fetch_cnt_o,
  output logic [15:0] data_cnt_o
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ACK
  } state_t;

  localparam logic [3:0] WCNT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  state_t     state_q, state_d;
  logic [3:0] wcnt_q, wcnt_d;
  logic       req;
  logic       complete;   // the closing edge of this cycle enters ACK
  logic       bad;        // the completing request is answered with an error
  logic       good_done;
  logic [DEPTH_LOG2-1:0] idx;
  logic [15:0] mem [0:(2**DEPTH_LOG2)-1];

  // Upper address bits are deliberately ignored in the aliasing build.
  logic unused_adr;
  assign unused_adr = ^adr_i;

  assign req = cyc_i & stb_i;
  assign idx = adr_i[DEPTH_LOG2:1];

`ifdef S16_RESP_ERR_EN
  logic oob;
  generate
    if (DEPTH_LOG2 < 15) begin : g_oob
      assign oob = |adr_i[15:DEPTH_LOG2+1];
    end else begin : g_no_oob
      assign oob = 1'b0;
    end
  endgenerate
  assign bad = oob | (we_i & vpa_i);
`else
  assign bad = 1'b0;
`endif

  assign good_done = complete & ~bad;

  always_comb begin
    state_d  = state_q;
    wcnt_d   = wcnt_q;
    complete = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          if (WAIT_STATES == 0) begin
            state_d  = ST_ACK;
            complete = 1'b1;
          end else begin
            state_d = ST_WAIT;
            wcnt_d  = WCNT_LOAD;
          end
        end
      end
      ST_WAIT: begin
        if (!req) begin
          // Master withdrew the request: abort with no side effect.
          state_d = ST_IDLE;
          wcnt_d  = 4'd0;
        end else if (wcnt_q == 4'd0) begin
          state_d  = ST_ACK;
          complete = 1'b1;
        end else begin
          wcnt_d = wcnt_q - 4'd1;
        end
      end
      ST_ACK: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        wcnt_d  = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      wcnt_q      <= 4'd0;
      ack_o       <= 1'b0;
      dat_o       <= 16'h0000;
      fetch_cnt_o <= 16'h0000;
      data_cnt_o  <= 16'h0000;
`ifdef S16_RESP_ERR_EN
      err_o       <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      ack_o   <= good_done;
      // Full word is returned regardless of sel_i; a write returns the pre-write word.
      dat_o   <= good_done ? mem[idx] : 16'h0000;
`ifdef S16_RESP_ERR_EN
      err_o   <= complete & bad;
`endif
      if (good_done && vpa_i && !vda_i) begin
        fetch_cnt_o <= fetch_cnt_o + 16'd1;
      end
      if (good_done && vda_i) begin
        data_cnt_o <= data_cnt_o + 16'd1;
      end
    end
  end

  // SRAM array has no reset; a write is dropped if reset coincides with completion.
  always_ff @(posedge clk_i) begin
    if (!reset && good_done && we_i) begin
      if (sel_i[0]) begin
        mem[idx][7:0] <= dat_i[7:0];
      end
      if (sel_i[1]) begin
        mem[idx][15:8] <= dat_i[15:8];
      end
    end
  end

endmodule
